drv_ad56x3_cfg_master: RTL and testbench

// - Avalon-MM master that programs the AD56x3 driver parameter register slave.
// - On start: optional soft reset, then writes genSel, ceDivider, incrRate0 and incrRate1.
// - Optionally reads the four registers back, compares them and reports done/error.
// - Also serves single host readback requests while idle.
// - Sits between the system control logic (or test harness) and the driver's parameter slave.

---
 rtl/drvAd56x3_pkg.sv | 48 ++++
 rtl/drv_ad56x3_cfg_master.sv | 147 ++++++++++++++
 tb/tb_drv_ad56x3_cfg_master.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/drvAd56x3_pkg.sv
// rtl/drvAd56x3_pkg.sv - shared addresses, slave default values and FSM states for the AD56x3 cfg master
package drvAd56x3_pkg;

    localparam logic [2:0] ADR_RST    = 3'd0;
    localparam logic [2:0] ADR_GENSEL = 3'd1;
    localparam logic [2:0] ADR_CEDIV  = 3'd2;
    localparam logic [2:0] ADR_INCR0  = 3'd3;
    localparam logic [2:0] ADR_INCR1  = 3'd4;

    localparam logic [15:0] RST_WORD = 16'h0001;

    // Values the parameter slave takes after reset or a soft reset
    localparam logic        DEF_GENSEL = 1'b0;
    localparam logic [15:0] DEF_CEDIV  = 16'd125;
    localparam logic [15:0] DEF_INCR0  = 16'd1;
    localparam logic [15:0] DEF_INCR1  = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_DONE,
        ST_SRD_REQ,
        ST_SRD_CAP
    } state_t;

    // Word written to / expected back from a register address
    function automatic logic [15:0] reg_word(
        input logic [2:0]  adr,
        input logic        gen_sel,
        input logic [15:0] ce_div,
        input logic [15:0] incr0,
        input logic [15:0] incr1
    );
        logic [15:0] word;
        case (adr)
            ADR_RST:    word = RST_WORD;
            ADR_GENSEL: word = {15'b0, gen_sel};
            ADR_CEDIV:  word = ce_div;
            ADR_INCR0:  word = incr0;
            ADR_INCR1:  word = incr1;
            default:    word = 16'h0000;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/drv_ad56x3_cfg_master.sv
// rtl/drv_ad56x3_cfg_master.sv - Avalon-MM master programming and verifying the AD56x3 parameter slave
module drv_ad56x3_cfg_master
    import drvAd56x3_pkg::*;
#(
    parameter int VERIFY   = 1,
    parameter int SOFT_RST = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cfgGenSel,
    input  logic [15:0] cfgCeDiv,
    input  logic [15:0] cfgIncr0,
    input  logic [15:0] cfgIncr1,
    input  logic        rdReq,
    input  logic [2:0]  rdAdr,
    output logic [15:0] rdData,
    output logic        rdValid,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  errAdr,
    output logic [2:0]  avmAdr,
    output logic        avmWr,
    output logic [15:0] avmWrData,
    output logic        avmRd,
    input  logic [15:0] avmRdData
);

    localparam logic [2:0] FIRST_ADR = (SOFT_RST != 0) ? ADR_RST : ADR_GENSEL;

    state_t      state, state_next;
    logic [2:0]  idx, idx_next;
    logic        sh_gen_sel;
    logic [15:0] sh_ce_div;
    logic [15:0] sh_incr0;
    logic [15:0] sh_incr1;
    logic [15:0] exp_word;
    logic        accept_start;
    logic        mismatch;

    assign exp_word = reg_word(idx, sh_gen_sel, sh_ce_div, sh_incr0, sh_incr1);

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        accept_start = 1'b0;
        mismatch     = 1'b0;
        avmAdr       = 3'd0;
        avmWr        = 1'b0;
        avmWrData    = 16'h0000;
        avmRd        = 1'b0;
        rdData       = 16'h0000;
        rdValid      = 1'b0;
        done         = 1'b0;
        busy         = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_next   = ST_WR;
                    idx_next     = FIRST_ADR;
                end else if (rdReq) begin
                    // idx doubles as the single-read address
                    state_next = ST_SRD_REQ;
                    idx_next   = rdAdr;
                end
            end
            ST_WR: begin
                avmWr     = 1'b1;
                avmAdr    = idx;
                avmWrData = exp_word;
                if (idx == ADR_INCR1) begin
                    if (VERIFY != 0) begin
                        state_next = ST_RD_REQ;
                        idx_next   = ADR_GENSEL;
                    end else begin
                        state_next = ST_DONE;
                    end
                end else begin
                    idx_next = idx + 3'd1;
                end
            end
            ST_RD_REQ: begin
                avmRd      = 1'b1;
                avmAdr     = idx;
                state_next = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                mismatch = (avmRdData != exp_word);
                if (idx == ADR_INCR1) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next   = idx + 3'd1;
                    state_next = ST_RD_REQ;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            ST_SRD_REQ: begin
                avmRd      = 1'b1;
                avmAdr     = idx;
                state_next = ST_SRD_CAP;
            end
            ST_SRD_CAP: begin
                rdValid    = 1'b1;
                rdData     = avmRdData;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            idx        <= 3'd0;
            sh_gen_sel <= 1'b0;
            sh_ce_div  <= 16'h0000;
            sh_incr0   <= 16'h0000;
            sh_incr1   <= 16'h0000;
            error      <= 1'b0;
            errAdr     <= 3'd0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (accept_start) begin
                sh_gen_sel <= cfgGenSel;
                // A divider of zero would stall the chip-enable generator
                sh_ce_div  <= (cfgCeDiv == 16'h0000) ? 16'h0001 : cfgCeDiv;
                sh_incr0   <= cfgIncr0;
                sh_incr1   <= cfgIncr1;
                error      <= 1'b0;
                errAdr     <= 3'd0;
            end else if (mismatch) begin
                error <= 1'b1;
                if (!error) begin
                    errAdr <= idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_drv_ad56x3_cfg_master.sv
// tb/tb_drv_ad56x3_cfg_master.sv - scoreboard bench for drv_ad56x3_cfg_master with a parameter slave model
module tb_drv_ad56x3_cfg_master;

    typedef struct {
        logic [2:0]  adr;
        logic [15:0] data;
        int          cyc;
    } ev_t;

    typedef struct {
        logic        gs;
        logic [15:0] ce;
        logic [15:0] i0;
        logic [15:0] i1;
        logic        corrupt;
        logic        with_rd;
        logic        exp_err;
        logic [2:0]  exp_eadr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, sl_rst_n;
    logic        start, cfgGenSel, rdReq;
    logic [15:0] cfgCeDiv, cfgIncr0, cfgIncr1;
    logic [2:0]  rdAdr;
    logic [15:0] rdData, avmWrData, avmRdData;
    logic        rdValid, busy, done, error, avmWr, avmRd;
    logic [2:0]  errAdr, avmAdr;

    logic        start2;
    logic [15:0] rdData2, avmWrData2;
    logic        rdValid2, busy2, done2, error2, avmWr2, avmRd2;
    logic [2:0]  errAdr2, avmAdr2;

    logic        s_gen, corrupt3;
    logic [15:0] s_ce, s_i0, s_i1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic       done_err;
    logic [2:0] done_eadr;
    ev_t wq[$];
    ev_t rq[$];
    ev_t vq[$];
    int  dq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    drv_ad56x3_cfg_master #(.VERIFY(1), .SOFT_RST(1)) dut (
        .clk(clk), .reset(rst_n), .start(start), .cfgGenSel(cfgGenSel),
        .cfgCeDiv(cfgCeDiv), .cfgIncr0(cfgIncr0), .cfgIncr1(cfgIncr1),
        .rdReq(rdReq), .rdAdr(rdAdr), .rdData(rdData), .rdValid(rdValid),
        .busy(busy), .done(done), .error(error), .errAdr(errAdr),
        .avmAdr(avmAdr), .avmWr(avmWr), .avmWrData(avmWrData), .avmRd(avmRd),
        .avmRdData(avmRdData)
    );

    drv_ad56x3_cfg_master #(.VERIFY(0), .SOFT_RST(0)) dut2 (
        .clk(clk), .reset(rst_n), .start(start2), .cfgGenSel(cfgGenSel),
        .cfgCeDiv(cfgCeDiv), .cfgIncr0(cfgIncr0), .cfgIncr1(cfgIncr1),
        .rdReq(1'b0), .rdAdr(3'd0), .rdData(rdData2), .rdValid(rdValid2),
        .busy(busy2), .done(done2), .error(error2), .errAdr(errAdr2),
        .avmAdr(avmAdr2), .avmWr(avmWr2), .avmWrData(avmWrData2), .avmRd(avmRd2),
        .avmRdData(16'h0000)
    );

    // Parameter slave model: writes on the strobe cycle, registered read data
    always @(posedge clk or negedge sl_rst_n) begin
        if (!sl_rst_n) begin
            s_gen <= 1'b0; s_ce <= 16'd125; s_i0 <= 16'd1; s_i1 <= 16'hFFFF;
            avmRdData <= 16'h0000;
        end else begin
            if (avmWr) begin
                case (avmAdr)
                    3'd0: if (avmWrData[0]) begin
                        s_gen <= 1'b0; s_ce <= 16'd125; s_i0 <= 16'd1; s_i1 <= 16'hFFFF;
                    end
                    3'd1: s_gen <= avmWrData[0];
                    3'd2: s_ce <= avmWrData;
                    3'd3: s_i0 <= avmWrData;
                    3'd4: s_i1 <= avmWrData;
                    default: ;
                endcase
            end
            avmRdData <= 16'h0000;
            if (avmRd) begin
                case (avmAdr)
                    3'd1: avmRdData <= {15'b0, s_gen};
                    3'd2: avmRdData <= s_ce;
                    3'd3: avmRdData <= corrupt3 ? 16'h0000 : s_i0;
                    3'd4: avmRdData <= s_i1;
                    default: avmRdData <= 16'h0000;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] wexp(input int a, input vec_t v);
        case (a)
            0: return 16'h0001;
            1: return {15'b0, v.gs};
            2: return (v.ce == 16'h0000) ? 16'h0001 : v.ce;
            3: return v.i0;
            default: return v.i1;
        endcase
    endfunction

    // Bus monitor and protocol checker, sampled on the falling edge
    always @(negedge clk) begin
        ev_t e;
        chk("strobe_overlap", {avmWr, avmRd}, (avmWr && avmRd) ? 2'b00 : {avmWr, avmRd});
        if (!avmWr && !avmRd) chk("idle_bus", {avmAdr, avmWrData}, 0);
        if (avmRd && !avmWr) chk("rd_wrdata", avmWrData, 0);
        if (avmWr) begin
            if (wq.size() == 0) chk("unexpected_write", {avmAdr, avmWrData}, 64'hDEAD);
            else begin
                e = wq.pop_front();
                chk("write", {avmAdr, avmWrData, cyc}, {e.adr, e.data, e.cyc});
            end
        end
        if (avmRd) begin
            if (rq.size() == 0) chk("unexpected_read", avmAdr, 64'hDEAD);
            else begin
                e = rq.pop_front();
                chk("read", {avmAdr, cyc}, {e.adr, e.cyc});
            end
        end
        if (rdValid) begin
            if (vq.size() == 0) chk("unexpected_rdvalid", rdData, 64'hDEAD);
            else begin
                e = vq.pop_front();
                chk("rdvalid", {rdData, cyc}, {e.data, e.cyc});
            end
        end
        if (done) begin
            if (dq.size() == 0) chk("unexpected_done", cyc, 64'hDEAD);
            else chk("done_cycle", cyc, dq.pop_front());
            done_err  = error;
            done_eadr = errAdr;
            done_cnt++;
        end
    end

    task automatic pulse_start(input vec_t v, input logic with_rd, output int t0);
        @(posedge clk); #1;
        t0 = cyc;
        corrupt3 = v.corrupt;
        cfgGenSel = v.gs; cfgCeDiv = v.ce; cfgIncr0 = v.i0; cfgIncr1 = v.i1;
        start = 1'b1; rdReq = with_rd; rdAdr = 3'd2;
        @(posedge clk); #1;
        start = 1'b0; rdReq = 1'b0;
    endtask

    task automatic push_seq(input vec_t v, input int t0);
        for (int a = 0; a <= 4; a++) wq.push_back('{a[2:0], wexp(a, v), t0 + 1 + a});
        for (int a = 1; a <= 4; a++) rq.push_back('{a[2:0], 16'h0, t0 + 4 + 2 * a});
        dq.push_back(t0 + 14);
    endtask

    task automatic wait_done(input int n0);
        int k = 0;
        while (done_cnt == n0 && k < 40) begin @(negedge clk); k++; end
        chk("done_seen", done_cnt - n0, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int t0;
        int n0 = done_cnt;
        pulse_start(v, v.with_rd, t0);
        push_seq(v, t0);
        @(negedge clk);
        chk("busy_cycle1", busy, 1);
        chk("err_clear", {error, errAdr}, 0);
        wait_done(n0);
        chk("err_at_done", {done_err, done_eadr}, {v.exp_err, v.exp_eadr});
        chk("queues_empty", {wq.size(), rq.size(), dq.size()}, 0);
        chk("slave_regs", {s_gen, s_ce, s_i0, s_i1}, {v.gs, wexp(2, v), v.i0, v.i1});
        @(negedge clk);
        chk("idle_after", {busy, error}, {1'b0, v.exp_err});
    endtask

    task automatic single_read(input logic [2:0] adr, input logic [15:0] exp);
        int t0;
        int k = 0;
        @(posedge clk); #1;
        t0 = cyc;
        rq.push_back('{adr, 16'h0, t0 + 1});
        vq.push_back('{3'd0, exp, t0 + 2});
        rdReq = 1'b1; rdAdr = adr;
        @(posedge clk); #1;
        rdReq = 1'b0;
        while (vq.size() != 0 && k < 10) begin @(negedge clk); k++; end
        chk("single_read_done", {vq.size(), rq.size()}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t vt[4];
        vec_t va, vb;
        logic [19:0] exp2;
        int t0;
        int n0;

        vt[0] = '{1'b1, 16'd250,   16'd3,     16'hFFF9, 1'b0, 1'b0, 1'b0, 3'd0};
        vt[1] = '{1'b0, 16'd0,     16'd17,    16'd42,   1'b0, 1'b1, 1'b0, 3'd0};
        vt[2] = '{1'b0, 16'd1000,  16'hFF9C,  16'd200,  1'b1, 1'b0, 1'b1, 3'd3};
        vt[3] = '{1'b1, 16'hFFFF,  16'h8000,  16'h7FFF, 1'b0, 1'b0, 1'b0, 3'd0};

        rst_n = 1'b0; sl_rst_n = 1'b0; start = 1'b0; start2 = 1'b0; rdReq = 1'b0;
        rdAdr = 3'd0; cfgGenSel = 1'b0; cfgCeDiv = 16'h0; cfgIncr0 = 16'h0; cfgIncr1 = 16'h0;
        corrupt3 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {rdData, rdValid, busy, done, error, errAdr, avmAdr, avmWr, avmWrData, avmRd}, 0);
        chk("reset_outputs2", {rdData2, rdValid2, busy2, done2, error2, errAdr2, avmAdr2, avmWr2, avmWrData2, avmRd2}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; sl_rst_n = 1'b1;
        repeat (2) @(posedge clk);

        single_read(3'd2, 16'd125);
        single_read(3'd6, 16'd0);

        for (int i = 0; i < 4; i++) run_vec(vt[i]);

        // Second start while busy must not disturb the running sequence
        va = '{1'b1, 16'd250, 16'd3, 16'hFFF9, 1'b0, 1'b0, 1'b0, 3'd0};
        n0 = done_cnt;
        pulse_start(va, 1'b0, t0);
        push_seq(va, t0);
        repeat (2) @(posedge clk);
        #1;
        cfgGenSel = 1'b0; cfgCeDiv = 16'd9; cfgIncr0 = 16'd9; cfgIncr1 = 16'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n0);
        chk("busy_start_err", {done_err, done_eadr}, 0);
        chk("busy_start_slave", {s_gen, s_ce, s_i0, s_i1}, {1'b1, 16'd250, 16'd3, 16'hFFF9});

        // Reset during the write burst aborts at once and leaves the slave half written
        repeat (2) @(posedge clk);
        vb = '{1'b1, 16'd777, 16'd5, 16'd6, 1'b0, 1'b0, 1'b0, 3'd0};
        n0 = done_cnt;
        pulse_start(vb, 1'b0, t0);
        wq.push_back('{3'd0, 16'h0001, t0 + 1});
        wq.push_back('{3'd1, 16'h0001, t0 + 2});
        start = 1'b1; cfgCeDiv = 16'd55;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", {rdData, rdValid, busy, done, error, errAdr, avmAdr, avmWr, avmWrData, avmRd}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midreset_no_done", done_cnt - n0, 0);
        chk("midreset_state", {busy, wq.size()}, 0);
        chk("midreset_slave", {s_gen, s_ce, s_i0, s_i1}, {1'b1, 16'd125, 16'd1, 16'hFFFF});

        // VERIFY=0, SOFT_RST=0 instance: writes on cycles 1..4, done on 5, no reads
        @(posedge clk); #1;
        cfgGenSel = 1'b1; cfgCeDiv = 16'd0; cfgIncr0 = 16'd11; cfgIncr1 = 16'hFFFE;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            case (k)
                1: exp2 = {1'b1, 3'd1, 16'h0001};
                2: exp2 = {1'b1, 3'd2, 16'h0001};
                3: exp2 = {1'b1, 3'd3, 16'd11};
                4: exp2 = {1'b1, 3'd4, 16'hFFFE};
                default: exp2 = 20'h0;
            endcase
            chk("nv_write", {avmWr2, avmAdr2, avmWrData2}, exp2);
            chk("nv_done", done2, (k == 5) ? 1'b1 : 1'b0);
            chk("nv_no_read", avmRd2, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
